// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares one single-read/single-write register file between two requesters
//   (A and B). The arbiter picks a winner in IDLE and latches its operation.
//   It then drives the register file for one ACCESS cycle and pulses the
//   winner's ack in RESP. Each transaction takes three cycles.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   a_req/a_we/a_num/a_wdata requester A: request, write enable, index, data
//   a_ack                    one-cycle completion pulse for A
//   b_req/b_we/b_num/b_wdata requester B: same as A
//   b_ack                    one-cycle completion pulse for B
//   rdata                    last read result, updated when a read completes
//   rf_write/rf_writenum/rf_readnum/rf_data_in   drive the register file
//   rf_data_out              combinational read data from the register file
module regfile_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int NUM_W      = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [NUM_W-1:0]  a_num,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [NUM_W-1:0]  b_num,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rf_write,
  output logic [NUM_W-1:0]  rf_writenum,
  output logic [NUM_W-1:0]  rf_readnum,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  state_e              state_q;
  grant_e              last_grant_q;
  grant_e              op_grant_q;
  logic                op_we_q;
  logic [NUM_W-1:0]    op_num_q;
  logic [DATA_W-1:0]   op_wdata_q;
  logic                a_ack_q;
  logic                b_ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rf_write_q;

  // Winner selection for the current IDLE cycle.
  grant_e              grant_d;
  logic                any_req_d;
  logic                sel_we_d;
  logic [NUM_W-1:0]    sel_num_d;
  logic [DATA_W-1:0]   sel_wdata_d;

  always_comb begin
    any_req_d = a_req | b_req;
    grant_d   = GNT_A;
    if (a_req && b_req) begin
      // Round-robin: B wins a tie only when A had the previous grant.
      if ((FIXED_PRIO == 0) && (last_grant_q == GNT_A)) begin
        grant_d = GNT_B;
      end
    end else if (b_req) begin
      grant_d = GNT_B;
    end

    if (grant_d == GNT_B) begin
      sel_we_d    = b_we;
      sel_num_d   = b_num;
      sel_wdata_d = b_wdata;
    end else begin
      sel_we_d    = a_we;
      sel_num_d   = a_num;
      sel_wdata_d = a_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_B;
      op_grant_q   <= GNT_A;
      op_we_q      <= 1'b0;
      op_num_q     <= '0;
      op_wdata_q   <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      rdata_q      <= '0;
      rf_write_q   <= 1'b0;
    end else begin
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      rf_write_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            op_grant_q   <= grant_d;
            last_grant_q <= grant_d;
            op_we_q      <= sel_we_d;
            op_num_q     <= sel_num_d;
            op_wdata_q   <= sel_wdata_d;
            // Register rf_write here so it is high exactly during ACCESS.
            rf_write_q   <= sel_we_d;
            state_q      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!op_we_q) begin
            rdata_q <= rf_data_out;
          end
          a_ack_q <= (op_grant_q == GNT_A);
          b_ack_q <= (op_grant_q == GNT_B);
          state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Index and data follow the op latches. These update only on a grant,
  // so they hold their last values outside ACCESS.
  assign rf_writenum = op_num_q;
  assign rf_readnum  = op_num_q;
  assign rf_data_in  = op_wdata_q;
  assign rf_write    = rf_write_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam bit SIDE_A = 1'b0;
  localparam bit SIDE_B = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- main DUT (round-robin) ----------------
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_num, b_num;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] rdata;
  logic        rf_write;
  logic [2:0]  rf_writenum, rf_readnum;
  logic [15:0] rf_data_in, rf_data_out;

  regfile_port_arbiter #(.DATA_W(16), .NUM_W(3), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_num(a_num), .a_wdata(a_wdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_num(b_num), .b_wdata(b_wdata), .b_ack(b_ack),
    .rdata(rdata), .rf_write(rf_write), .rf_writenum(rf_writenum),
    .rf_readnum(rf_readnum), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
  );

  // Register file environment: combinational read, clocked write, never cleared by reset.
  bit [15:0] env_rf [8];
  assign rf_data_out = env_rf[rf_readnum];
  always @(posedge clk) if (rf_write) env_rf[rf_writenum] <= rf_data_in;

  // ---------------- fixed-priority DUT ----------------
  logic        f_rst_n;
  logic        fa_req, fa_we, fb_req, fb_we;
  logic [2:0]  fa_num, fb_num;
  logic [15:0] fa_wdata, fb_wdata;
  logic        fa_ack, fb_ack;
  logic [15:0] f_rdata;
  logic        f_write;
  logic [2:0]  f_writenum, f_readnum;
  logic [15:0] f_data_in;
  logic [15:0] f_data_out;
  assign f_data_out = 16'h0F0F;
  bit fp_done;

  regfile_port_arbiter #(.DATA_W(16), .NUM_W(3), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(f_rst_n),
    .a_req(fa_req), .a_we(fa_we), .a_num(fa_num), .a_wdata(fa_wdata), .a_ack(fa_ack),
    .b_req(fb_req), .b_we(fb_we), .b_num(fb_num), .b_wdata(fb_wdata), .b_ack(fb_ack),
    .rdata(f_rdata), .rf_write(f_write), .rf_writenum(f_writenum),
    .rf_readnum(f_readnum), .rf_data_in(f_data_in), .rf_data_out(f_data_out)
  );

  // ---------------- behavioural model ----------------
  // A transaction is tracked by its age since grant: age 1 is the register-file
  // access cycle, age 2 is the ack cycle, and -1 means the port is free.
  bit [15:0] mrf [8];
  int        age;
  bit        m_who, m_we, m_last;
  bit [2:0]  m_num;
  bit [15:0] m_wdata, exp_rdata;
  int        wr_cycles = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age       <= -1;
      m_last    <= SIDE_B;
      m_who     <= SIDE_A;
      m_we      <= 1'b0;
      m_num     <= '0;
      m_wdata   <= '0;
      exp_rdata <= '0;
    end else if (age == 1) begin
      if (m_we) mrf[m_num] <= m_wdata;
      else      exp_rdata  <= mrf[m_num];
      age <= 2;
    end else if (age == 2) begin
      age <= -1;
    end else if (a_req || b_req) begin
      bit who;
      if (a_req && b_req) who = ~m_last;
      else                who = b_req;
      m_who   <= who;
      m_last  <= who;
      m_we    <= who ? b_we    : a_we;
      m_num   <= who ? b_num   : a_num;
      m_wdata <= who ? b_wdata : a_wdata;
      age     <= 1;
    end
  end

  // Every-cycle comparison of the main DUT against the model.
  always @(negedge clk) begin
    chk("rf_write",    rf_write,    (age == 1) && m_we);
    chk("a_ack",       a_ack,       (age == 2) && (m_who == SIDE_A));
    chk("b_ack",       b_ack,       (age == 2) && (m_who == SIDE_B));
    chk("rdata",       rdata,       exp_rdata);
    chk("rf_writenum", rf_writenum, m_num);
    chk("rf_readnum",  rf_readnum,  m_num);
    chk("rf_data_in",  rf_data_in,  m_wdata);
    if (rf_write) wr_cycles++;
  end

  // One transaction on a side: wait a cycle, raise req, wait (bounded) for ack, drop req.
  task automatic txn(input bit side, input bit we, input bit [2:0] num, input bit [15:0] wd,
                     output bit [15:0] rd, output int lat);
    bit got = 0;
    @(negedge clk);
    if (side == SIDE_B) begin b_req = 1; b_we = we; b_num = num; b_wdata = wd; end
    else                begin a_req = 1; a_we = we; a_num = num; a_wdata = wd; end
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      if ((side == SIDE_B) ? b_ack : a_ack) begin
        got = 1;
        lat = i;
        rd  = rdata;
      end
    end
    if (side == SIDE_B) b_req = 0; else a_req = 0;
    if (!got) chk("txn_timeout", 0, 1);
  endtask

  // ---------------- fixed-priority stimulus ----------------
  initial begin
    int na, nb;
    f_rst_n = 0; fa_req = 0; fb_req = 0; fa_we = 0; fb_we = 0;
    fa_num = 3'd2; fb_num = 3'd4; fa_wdata = '0; fb_wdata = '0;
    repeat (3) @(negedge clk);
    f_rst_n = 1;
    @(negedge clk);
    fa_req = 1; fb_req = 1;
    na = 0; nb = 0;
    repeat (30) begin
      @(negedge clk);
      if (fa_ack) na++;
      if (fb_ack) nb++;
    end
    fa_req = 0; fb_req = 0;
    chk("fp_a_grants", na, 10);
    chk("fp_b_grants", nb, 0);
    chk("fp_rdata", f_rdata, 16'h0F0F);
    fp_done = 1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    bit [15:0] rd;
    int        lat, w0;
    bit        who_log [$];
    int        cyc_log [$];
    int        cnt;
    bit        exp_order [6];
    exp_order = '{0, 1, 0, 1, 0, 1};

    rst_n = 0;
    a_req = 0; a_we = 0; a_num = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_num = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rf_write", rf_write, 0);
    chk("rst_rf_writenum", rf_writenum, 0);
    chk("rst_rf_data_in", rf_data_in, 0);
    rst_n = 1;

    // A writes R3 = BEEF.
    @(negedge clk);
    a_req = 1; a_we = 1; a_num = 3'd3; a_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t1_c1_rf_write", rf_write, 1);
    chk("t1_c1_writenum", rf_writenum, 3);
    chk("t1_c1_data_in", rf_data_in, 16'hBEEF);
    chk("t1_c1_a_ack", a_ack, 0);
    @(negedge clk);
    chk("t1_c2_a_ack", a_ack, 1);
    chk("t1_c2_b_ack", b_ack, 0);
    chk("t1_c2_rf_write", rf_write, 0);
    a_req = 0;

    // B reads R3.
    w0 = wr_cycles;
    txn(SIDE_B, 0, 3'd3, 16'h0, rd, lat);
    chk("t2_latency", lat, 2);
    chk("t2_rdata", rd, 16'hBEEF);
    chk("t2_no_write", wr_cycles - w0, 0);

    // Both request continuously: round-robin alternation.
    @(negedge clk);
    a_req = 1; a_we = 0; a_num = 3'd3;
    b_req = 1; b_we = 0; b_num = 3'd1;
    cnt = 0;
    for (int i = 0; i < 40 && who_log.size() < 6; i++) begin
      @(negedge clk);
      cnt++;
      if (a_ack) begin who_log.push_back(SIDE_A); cyc_log.push_back(cnt); end
      if (b_ack) begin who_log.push_back(SIDE_B); cyc_log.push_back(cnt); end
    end
    a_req = 0; b_req = 0;
    chk("t3_ack_count", who_log.size(), 6);
    if (who_log.size() == 6) begin
      for (int k = 0; k < 6; k++) chk($sformatf("t3_order_%0d", k), who_log[k], exp_order[k]);
      chk("t3_first_ack", cyc_log[0], 2);
      for (int k = 1; k < 6; k++) chk($sformatf("t3_spacing_%0d", k), cyc_log[k] - cyc_log[k-1], 3);
    end

    // Write R7 then read it; rdata holds through a following write.
    txn(SIDE_A, 1, 3'd7, 16'h1234, rd, lat);
    chk("t5_wr_latency", lat, 2);
    txn(SIDE_A, 0, 3'd7, 16'h0, rd, lat);
    chk("t5_rd_rdata", rd, 16'h1234);
    txn(SIDE_A, 1, 3'd0, 16'h5555, rd, lat);
    chk("t5_hold_rdata", rd, 16'h1234);

    // Reset asserted during the ACCESS cycle of a write.
    @(negedge clk);
    a_req = 1; a_we = 1; a_num = 3'd5; a_wdata = 16'hAAAA;
    @(negedge clk);
    chk("t6_access_write", rf_write, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_async_rf_write", rf_write, 0);
    chk("t6_async_a_ack", a_ack, 0);
    a_req = 0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_ack || b_ack) cnt++;
    end
    chk("t6_no_ack", cnt, 0);
    rst_n = 1;
    txn(SIDE_A, 0, 3'd5, 16'h0, rd, lat);
    chk("t6_post_latency", lat, 2);
    chk("t6_dropped_write", rd, 16'h0000);
    txn(SIDE_B, 0, 3'd7, 16'h0, rd, lat);
    chk("t6_rf_kept", rd, 16'h1234);

    cnt = 0;
    while (!fp_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (!fp_done) chk("fp_timeout", 0, 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
